// File: rtl/mixer_lo_pkg.sv
// Shared definitions for the mixer LO sequencer.
//   LO_*      : 2-bit mixer control codes (bit1 = negate, bit0 = pass)
//   mode_e    : LO waveform selection
//   state_e   : sequencer FSM states
//   lo_pair_t : one I/Q code pair as produced by the lookup table
package mixer_lo_pkg;

    localparam logic [1:0] LO_ZERO = 2'b00;
    localparam logic [1:0] LO_POS  = 2'b01;
    localparam logic [1:0] LO_NEG  = 2'b10;

    typedef enum logic [1:0] {
        MODE_FS4  = 2'b00,
        MODE_DC   = 2'b01,
        MODE_FS2  = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] q;
    } lo_pair_t;

endpackage

// File: rtl/mixer_lo_table.sv
// Combinational 4-phase LO lookup.
//   mode     in  waveform selection
//   sideband in  0: Q follows -sin, 1: Q follows +sin (fs/4 only)
//   phase    in  table index 0..3
//   lo       out {I code, Q code}
module mixer_lo_table
    import mixer_lo_pkg::*;
(
    input  mode_e      mode,
    input  logic       sideband,
    input  logic [1:0] phase,
    output lo_pair_t   lo
);

    always_comb begin
        lo.i = LO_ZERO;
        lo.q = LO_ZERO;
        case (mode)
            MODE_FS4: begin
                case (phase)
                    2'd0: lo.i = LO_POS;
                    2'd1: lo.q = sideband ? LO_POS : LO_NEG;
                    2'd2: lo.i = LO_NEG;
                    default: lo.q = sideband ? LO_NEG : LO_POS;
                endcase
            end
            MODE_DC:  lo.i = LO_POS;
            MODE_FS2: lo.i = phase[0] ? LO_NEG : LO_POS;
            default: ;
        endcase
    end

endmodule

// File: rtl/mixer_lo_sequencer.sv
// Mixer LO sequencer: steps a 4-phase I/Q code table at cfg_div+1 clocks
// per phase. Config written in IDLE applies at once; config written while
// busy is held in a single pending slot and applied at the next 3->0 phase
// boundary so a period is never mixed from two configurations.
//   clock, reset_n          : clock, async active-low reset
//   start, stop             : begin sequencing / finish period then idle
//   cfg_valid/cfg_ready     : config handshake for cfg_div/cfg_mode/cfg_sideband
//   LO_i, LO_q              : registered mixer codes
//   sample_en               : first cycle of each new LO value
//   phase                   : current table index
//   period_done             : pulse at each period end
//   busy                    : RUN or DRAIN
module mixer_lo_sequencer
    import mixer_lo_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_sideband,
    output logic [1:0]       LO_i,
    output logic [1:0]       LO_q,
    output logic             sample_en,
    output logic [1:0]       phase,
    output logic             period_done,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d, pdiv_q, pdiv_d;
    mode_e            mode_q, mode_d, pmode_q, pmode_d;
    logic             sb_q, sb_d, psb_q, psb_d;
    logic             pend_q, pend_d;
    logic [1:0]       phase_d, lo_i_d, lo_q_d;
    logic             sample_en_d, period_done_d;

    logic             last_tick, wrap, use_pend;
    mode_e            tbl_mode;
    logic             tbl_sb;
    logic [1:0]       tbl_phase;
    lo_pair_t         tbl_lo;

    // Both are pure decodes of flops, so they carry no input-to-output path.
    assign busy      = (state_q != IDLE);
    assign cfg_ready = (state_q == IDLE) || !pend_q;

    assign last_tick = (cnt_q == div_q);
    assign wrap      = last_tick && (phase == 2'd3);
    // At the period boundary the table must already see the pending config
    // so the new phase-0 value comes from the new table.
    assign use_pend  = wrap && pend_q;
    assign tbl_mode  = use_pend ? pmode_q : mode_q;
    assign tbl_sb    = use_pend ? psb_q   : sb_q;
    assign tbl_phase = (state_q == IDLE) ? 2'd0 : phase + 2'd1;

    mixer_lo_table u_table (
        .mode     (tbl_mode),
        .sideband (tbl_sb),
        .phase    (tbl_phase),
        .lo       (tbl_lo)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        mode_d        = mode_q;
        sb_d          = sb_q;
        pdiv_d        = pdiv_q;
        pmode_d       = pmode_q;
        psb_d         = psb_q;
        pend_d        = pend_q;
        phase_d       = phase;
        lo_i_d        = LO_i;
        lo_q_d        = LO_q;
        sample_en_d   = 1'b0;
        period_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_valid) begin
                    div_d  = cfg_div;
                    mode_d = mode_e'(cfg_mode);
                    sb_d   = cfg_sideband;
                end
                if (start && !stop) begin
                    state_d     = RUN;
                    phase_d     = 2'd0;
                    lo_i_d      = tbl_lo.i;
                    lo_q_d      = tbl_lo.q;
                    sample_en_d = 1'b1;
                end
            end
            default: begin
                // cfg_ready is !pend_q here, so load and apply never collide.
                if (cfg_valid && !pend_q) begin
                    pdiv_d  = cfg_div;
                    pmode_d = mode_e'(cfg_mode);
                    psb_d   = cfg_sideband;
                    pend_d  = 1'b1;
                end
                if (last_tick) begin
                    cnt_d       = '0;
                    phase_d     = phase + 2'd1;
                    lo_i_d      = tbl_lo.i;
                    lo_q_d      = tbl_lo.q;
                    sample_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (wrap) begin
                    period_done_d = 1'b1;
                    if (pend_q) begin
                        div_d  = pdiv_q;
                        mode_d = pmode_q;
                        sb_d   = psb_q;
                        pend_d = 1'b0;
                    end
                    // Stop landing on the final tick skips DRAIN entirely.
                    if (state_q == DRAIN || stop) begin
                        state_d     = IDLE;
                        phase_d     = 2'd0;
                        lo_i_d      = LO_ZERO;
                        lo_q_d      = LO_ZERO;
                        sample_en_d = 1'b0;
                    end
                end else if (state_q == RUN && stop) begin
                    state_d = DRAIN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            mode_q      <= MODE_FS4;
            sb_q        <= 1'b0;
            pdiv_q      <= '0;
            pmode_q     <= MODE_FS4;
            psb_q       <= 1'b0;
            pend_q      <= 1'b0;
            phase       <= 2'd0;
            LO_i        <= LO_ZERO;
            LO_q        <= LO_ZERO;
            sample_en   <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            sb_q        <= sb_d;
            pdiv_q      <= pdiv_d;
            pmode_q     <= pmode_d;
            psb_q       <= psb_d;
            pend_q      <= pend_d;
            phase       <= phase_d;
            LO_i        <= lo_i_d;
            LO_q        <= lo_q_d;
            sample_en   <= sample_en_d;
            period_done <= period_done_d;
        end
    end

endmodule

// File: tb/tb_mixer_lo_sequencer.sv
// Scoreboard bench for mixer_lo_sequencer: stimulus pushes hand-computed
// {LO_i, LO_q, phase, period_done} entries; a negedge monitor pops one
// whenever the DUT raises sample_en or period_done.
module tb_mixer_lo_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, stop, cfg_valid, cfg_ready, cfg_sideband;
    logic [7:0] cfg_div;
    logic [1:0] cfg_mode;
    logic [1:0] LO_i, LO_q, phase;
    logic       sample_en, period_done, busy;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] q;
        logic [1:0] ph;
        logic       pd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mixer_lo_sequencer #(.DIV_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div      (cfg_div),
        .cfg_mode     (cfg_mode),
        .cfg_sideband (cfg_sideband),
        .LO_i         (LO_i),
        .LO_q         (LO_q),
        .sample_en    (sample_en),
        .phase        (phase),
        .period_done  (period_done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] i, input logic [1:0] q, input logic [1:0] ph, input logic pd);
        exp_t e;
        e.i = i; e.q = q; e.ph = ph; e.pd = pd;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic config_idle(input logic [7:0] d, input logic [1:0] m, input logic sb);
        cfg_valid = 1'b1; cfg_div = d; cfg_mode = m; cfg_sideband = sb;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every presented output must match the next expected entry.
    always @(negedge clock) begin
        if (reset_n && (sample_en || period_done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {LO_i, LO_q, phase, period_done}, 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("lo_out", {LO_i, LO_q, phase, period_done}, {e.i, e.q, e.ph, e.pd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_div = '0; cfg_mode = 2'b00; cfg_sideband = 1'b0;
        #3;
        chk("rst_lo",    {LO_i, LO_q}, 4'b0000);
        chk("rst_phase", phase, 2'd0);
        chk("rst_flags", {sample_en, period_done, busy, cfg_ready}, 4'b0001);
        #10 reset_n = 1'b1;
        tick();

        // fs/4 sb0 div0: one value per clock, period_done each 4th.
        config_idle(8'd0, 2'b00, 1'b0);
        for (int p = 0; p < 3; p++) begin
            push(2'b01, 2'b00, 2'd0, p != 0);
            push(2'b00, 2'b10, 2'd1, 1'b0);
            push(2'b10, 2'b00, 2'd2, 1'b0);
            push(2'b00, 2'b01, 2'd3, 1'b0);
        end
        push(2'b00, 2'b00, 2'd0, 1'b1);
        do_start();                      // E0
        chk("run_busy", busy, 1'b1);
        tick(9);                         // E9: phase 1
        stop = 1'b1;
        tick();                          // E10: DRAIN, phase 2
        stop = 1'b0;
        tick();                          // E11: phase 3
        chk("drain_busy", busy, 1'b1);
        tick();                          // E12: back to IDLE
        chk("stop_idle", {busy, LO_i, LO_q, phase}, 7'b0);

        // fs/4 sb1 div2: each value held 3 clocks.
        config_idle(8'd2, 2'b00, 1'b1);
        for (int p = 0; p < 2; p++) begin
            push(2'b01, 2'b00, 2'd0, p != 0);
            push(2'b00, 2'b01, 2'd1, 1'b0);
            push(2'b10, 2'b00, 2'd2, 1'b0);
            push(2'b00, 2'b10, 2'd3, 1'b0);
        end
        push(2'b00, 2'b00, 2'd0, 1'b1);
        do_start();                      // E0
        chk("div2_se0", sample_en, 1'b1);
        tick();
        chk("div2_hold", {sample_en, LO_i}, 3'b0_01);
        tick();
        chk("div2_se2", sample_en, 1'b0);
        tick();
        chk("div2_se3", {sample_en, phase}, 3'b1_01);
        tick(10);                        // E13
        stop = 1'b1;
        tick();                          // E14
        stop = 1'b0;
        tick(10);                        // E24: IDLE
        chk("div2_idle", busy, 1'b0);

        // Mode change to fs/2 offered at phase 1.
        config_idle(8'd0, 2'b00, 1'b0);
        push(2'b01, 2'b00, 2'd0, 1'b0);
        push(2'b00, 2'b10, 2'd1, 1'b0);
        push(2'b10, 2'b00, 2'd2, 1'b0);
        push(2'b00, 2'b01, 2'd3, 1'b0);
        push(2'b01, 2'b00, 2'd0, 1'b1);
        push(2'b10, 2'b00, 2'd1, 1'b0);
        push(2'b01, 2'b00, 2'd2, 1'b0);
        push(2'b10, 2'b00, 2'd3, 1'b0);
        push(2'b00, 2'b00, 2'd0, 1'b1);
        do_start();                      // E0
        tick();                          // E1: phase 1
        chk("chg_ready_pre", cfg_ready, 1'b1);
        cfg_valid = 1'b1; cfg_div = 8'd0; cfg_mode = 2'b10; cfg_sideband = 1'b0;
        tick();                          // E2: transfer
        cfg_valid = 1'b0;
        chk("chg_ready_held", cfg_ready, 1'b0);
        tick();                          // E3
        chk("chg_ready_ph3", cfg_ready, 1'b0);
        tick();                          // E4: applied
        chk("chg_ready_post", cfg_ready, 1'b1);
        tick();                          // E5
        stop = 1'b1;
        tick();                          // E6
        stop = 1'b0;
        tick(2);                         // E8: IDLE
        chk("chg_idle", busy, 1'b0);

        // start together with stop in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_idle", {busy, sample_en}, 2'b00);
        tick(2);
        chk("startstop_still", busy, 1'b0);

        // Mute div1: codes stay 00, phase still cycles.
        config_idle(8'd1, 2'b11, 1'b0);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++)
                push(2'b00, 2'b00, k[1:0], (p != 0) && (k == 0));
        push(2'b00, 2'b00, 2'd0, 1'b1);
        do_start();                      // E0
        chk("mute_se0", sample_en, 1'b1);
        tick();
        chk("mute_se1", {sample_en, phase}, 3'b0_00);
        tick(8);                         // E9
        stop = 1'b1;
        tick();                          // E10
        stop = 1'b0;
        tick(6);                         // E16: IDLE
        chk("mute_idle", busy, 1'b0);

        // Reset mid-DRAIN with a pending mute config; defaults must return.
        config_idle(8'd0, 2'b00, 1'b0);
        push(2'b01, 2'b00, 2'd0, 1'b0);
        push(2'b00, 2'b10, 2'd1, 1'b0);
        push(2'b10, 2'b00, 2'd2, 1'b0);
        do_start();                      // E0
        stop = 1'b1;
        cfg_valid = 1'b1; cfg_div = 8'd0; cfg_mode = 2'b11; cfg_sideband = 1'b0;
        tick();                          // E1: DRAIN + pending
        stop = 1'b0; cfg_valid = 1'b0;
        chk("drain_pending", {busy, cfg_ready}, 2'b10);
        tick();                          // E2
        #5 reset_n = 1'b0;
        #1;
        chk("mid_rst_lo",    {LO_i, LO_q, phase}, 6'b0);
        chk("mid_rst_flags", {sample_en, period_done, busy, cfg_ready}, 4'b0001);
        #1 reset_n = 1'b1;
        tick();
        push(2'b01, 2'b00, 2'd0, 1'b0);
        push(2'b00, 2'b10, 2'd1, 1'b0);
        push(2'b10, 2'b00, 2'd2, 1'b0);
        push(2'b00, 2'b01, 2'd3, 1'b0);
        push(2'b00, 2'b00, 2'd0, 1'b1);
        do_start();                      // E0
        stop = 1'b1;
        tick();                          // E1
        stop = 1'b0;
        tick(3);                         // E4: IDLE
        chk("post_rst_idle", busy, 1'b0);

        tick(4);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mixer_lo_sequencer.md
Name: mixer_lo_sequencer

Overview:
- Generates the 2-bit LO_i/LO_q control codes that drive the IQ mixer's sign/zero selection.
- Steps a 4-phase LO table at a programmable rate.
- Accepts configuration through a valid/ready handshake. Changes made while running take effect only at a period boundary, so the mixed output never glitches.
- Sits between the control register block and the mixer, in the same clock domain.

Parameters:
- DIV_W, 8, width of the phase-step divider (clocks per phase = cfg_div+1).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin sequencing (honoured only in IDLE)
- stop  in  1  pulse; finish current LO period, then idle
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config can be accepted this cycle
- cfg_div  in  DIV_W  clocks-per-phase minus one
- cfg_mode  in  2  00 fs/4 quadrature, 01 DC, 10 fs/2, 11 mute
- cfg_sideband  in  1  0 = Q table -sin, 1 = Q table +sin
- LO_i  out  2  I code: 00 zero, 01 +1, 10 -1 (bit1 has priority, so 11 also means -1)
- LO_q  out  2  Q code, same encoding
- sample_en  out  1  high on the first cycle of each new LO value
- phase  out  2  current table index
- period_done  out  1  one-cycle pulse at each period end
- busy  out  1  high in RUN or DRAIN

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert handled upstream):
  - State IDLE.
  - LO_i = LO_q = 00, phase = 0.
  - sample_en = period_done = busy = 0, cfg_ready = 1.
  - Active config: div = 0, mode = 00, sideband = 0.
  - Pending config cleared; divider counter = 0.
- States:
  - IDLE: LO outputs are 00.
  - RUN.
  - DRAIN.
- Transitions:
  - IDLE + start & !stop -> RUN on the next edge. On that edge: phase = 0, counter = 0, LO = table[0], sample_en = 1.
  - start together with stop in IDLE: remain IDLE.
  - start in RUN or DRAIN: ignored.
  - RUN + stop -> DRAIN, outputs unchanged. If stop arrives on the last tick of phase 3, go directly to IDLE.
  - DRAIN at the end of phase 3 -> IDLE. On that edge: LO = 00, phase = 0, period_done = 1.
- Divider:
  - Counter runs 0..div. At div it wraps to 0, phase increments mod 4, and LO is updated from the table.
  - sample_en is high in the cycle the new LO value appears.
  - div = 0 means a phase step every clock. div = 255 means 256 clocks per phase.
- Period wrap: when phase goes 3 -> 0 in RUN, period_done pulses coincident with the phase-0 sample_en.
- Tables by phase 0..3:
  - fs/4: I = 01, 00, 10, 00. Q (sideband 0) = 00, 10, 00, 01. Q (sideband 1) = 00, 01, 00, 10.
  - DC: I = 01, Q = 00 at every phase.
  - fs/2: I = 01, 10, 01, 10. Q = 00.
  - Mute: I = Q = 00. Counter, phase and sample_en continue.
- Config handshake: transfer occurs when cfg_valid & cfg_ready.
  - In IDLE: cfg_ready = 1 and the transfer writes the active config directly.
  - In RUN or DRAIN: cfg_ready = !pend_valid. The transfer loads the pending registers.
  - Pending config is applied at the next phase 3 -> 0 boundary, including the DRAIN -> IDLE edge. The new div and table take effect from the new phase-0 value onward, and pend_valid clears on that edge.
- Only one pending config is held. A second offer stalls (cfg_ready = 0) until it is applied.
- Reset mid-operation: everything returns to reset values immediately and any pending config is lost.

Decomposition:
- Package mixer_lo_pkg holds:
  - LO code constants: LO_ZERO = 2'b00, LO_POS = 2'b01, LO_NEG = 2'b10.
  - Mode enum: MODE_FS4, MODE_DC, MODE_FS2, MODE_MUTE.
  - State enum: IDLE, RUN, DRAIN.
- One sub-module, mixer_lo_table: a combinational lookup (mode, sideband, phase) -> {LO_i, LO_q}.

Test Plan:
- Reset, configure div=0, mode fs/4, sideband 0 in IDLE, start -> from the next cycle LO_i = 01,00,10,00 repeating; LO_q = 00,10,00,01; sample_en high every cycle; period_done every 4th cycle at phase 0.
- div=2, fs/4, start -> each LO value is held for 3 clocks; sample_en high 1 of every 3 clocks; 12-clock period.
- While running fs/4 div=0 at phase 1, offer mode=fs/2 -> cfg_ready drops after the transfer; phases 2 and 3 still follow fs/4; from the next phase 0, LO_i = 01,10,01,10 and LO_q = 00; cfg_ready returns to 1.
- stop asserted at phase 1 (div=0) -> busy stays high through phase 3; the next cycle shows LO = 00, phase = 0, busy = 0, period_done = 1. Separately, start and stop together in IDLE -> stays IDLE.
- reset_n pulled low mid-DRAIN with a pending config -> all outputs go to reset values with no clock edge; after release, start runs the original active config.
- mode=mute, div=1, start -> LO_i = LO_q = 00 throughout; sample_en every 2nd clock; phase cycles 0..3.
